// File: rtl/counter_pkg.sv
// Shared types and constants for the game counter and its referee.
package counter_pkg;

  localparam int COUNTER_W = 8;

  typedef enum logic [1:0] {PLAY, RELOAD, OVER} referee_state_e;

  typedef enum logic [1:0] {
    WHO_NONE = 2'b00,
    WHO_WIN  = 2'b01,
    WHO_LOSE = 2'b10,
    WHO_DRAW = 2'b11
  } who_e;

endpackage

// File: rtl/rise_detect.sv
// Synchronous rising-edge detector: pulse is high in the cycle d first reads 1.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= d;
  end

  assign pulse = d & ~prev;

endmodule

// File: rtl/counter_referee.sv
// Referee beside the 8-bit game counter: tallies winner/loser events,
// reloads the counter after each score and calls the game when a side maxes out.
//
// state  | meaning
// PLAY   | waiting for a scored event
// RELOAD | init_out high this cycle, counter being reloaded
// OVER   | a tally hit WIN_MAX; tallies frozen until restart
module counter_referee
  import counter_pkg::*;
#(
  parameter int                   TALLY_W    = 4,
  parameter int                   WIN_MAX    = 15,
  parameter logic [COUNTER_W-1:0] RELOAD_VAL = 8'h80
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 winner_in,
  input  logic                 loser_in,
  input  logic                 restart,
  output logic                 init_out,
  output logic [COUNTER_W-1:0] load_out,
  output logic [TALLY_W-1:0]   win_tally,
  output logic [TALLY_W-1:0]   lose_tally,
  output logic                 game_over,
  output logic [1:0]           who
);

  localparam logic [TALLY_W-1:0] WIN_MAX_T = TALLY_W'(WIN_MAX);

  referee_state_e     state;
  logic               win_pulse, lose_pulse;
  logic [TALLY_W-1:0] win_next, lose_next;
  logic               win_hit, lose_hit;

  rise_detect u_win_edge (
    .clk  (clk),
    .reset(reset),
    .d    (winner_in),
    .pulse(win_pulse)
  );

  rise_detect u_lose_edge (
    .clk  (clk),
    .reset(reset),
    .d    (loser_in),
    .pulse(lose_pulse)
  );

  // Tallies are below WIN_MAX outside OVER, so the increment cannot wrap.
  always_comb begin
    win_next  = win_tally + TALLY_W'(win_pulse);
    lose_next = lose_tally + TALLY_W'(lose_pulse);
    win_hit   = win_pulse && (win_next == WIN_MAX_T);
    lose_hit  = lose_pulse && (lose_next == WIN_MAX_T);
  end

  always_ff @(posedge clk) begin
    load_out <= RELOAD_VAL;
    if (reset) begin
      state      <= PLAY;
      win_tally  <= '0;
      lose_tally <= '0;
      init_out   <= 1'b0;
      game_over  <= 1'b0;
      who        <= WHO_NONE;
    end else if (restart) begin
      state      <= RELOAD;
      win_tally  <= '0;
      lose_tally <= '0;
      init_out   <= 1'b1;
      game_over  <= 1'b0;
      who        <= WHO_NONE;
    end else begin
      unique case (state)
        PLAY, RELOAD: begin
          if (win_pulse || lose_pulse) begin
            win_tally  <= win_next;
            lose_tally <= lose_next;
            if (win_hit || lose_hit) begin
              state     <= OVER;
              init_out  <= 1'b0;
              game_over <= 1'b1;
              who       <= (win_hit && lose_hit) ? WHO_DRAW :
                           win_hit ? WHO_WIN : WHO_LOSE;
            end else begin
              state    <= RELOAD;
              init_out <= 1'b1;
            end
          end else begin
            state    <= PLAY;
            init_out <= 1'b0;
          end
        end
        OVER: begin
          init_out  <= 1'b0;
          game_over <= 1'b1;
        end
        default: begin
          state    <= PLAY;
          init_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_referee.sv
// Scoreboard bench for counter_referee: directed stimulus queues expected outputs,
// a negedge monitor pops and compares them cycle by cycle.
module tb_counter_referee;

  logic       clk = 1'b0;
  logic       reset;
  logic       winner_in;
  logic       loser_in;
  logic       restart;
  logic       init_out;
  logic [7:0] load_out;
  logic [3:0] win_tally;
  logic [3:0] lose_tally;
  logic       game_over;
  logic [1:0] who;

  counter_referee dut (
    .clk       (clk),
    .reset     (reset),
    .winner_in (winner_in),
    .loser_in  (loser_in),
    .restart   (restart),
    .init_out  (init_out),
    .load_out  (load_out),
    .win_tally (win_tally),
    .lose_tally(lose_tally),
    .game_over (game_over),
    .who       (who)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] wt;
    logic [3:0] lt;
    logic       init;
    logic       go;
    logic [1:0] who;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs are compared half a cycle after the edge they belong to.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL %s: stale entry for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
        end else if (win_tally !== e.wt || lose_tally !== e.lt || init_out !== e.init ||
                     game_over !== e.go || who !== e.who || load_out !== 8'h80) begin
          errors++;
          $display("FAIL %s cyc %0d: got wt=%0d lt=%0d init=%0b go=%0b who=%b load=%h, want wt=%0d lt=%0d init=%0b go=%0b who=%b load=80",
                   e.name, cyc, win_tally, lose_tally, init_out, game_over, who, load_out,
                   e.wt, e.lt, e.init, e.go, e.who);
        end
      end
    end
  end

  // Queue what the outputs must show after the next rising edge, then take that edge.
  task automatic step(input string name, input int wt, input int lt,
                      input bit init, input bit go, input logic [1:0] who_v);
    exp_t e;
    e.cyc  = cyc + 1;
    e.name = name;
    e.wt   = 4'(wt);
    e.lt   = 4'(lt);
    e.init = init;
    e.go   = go;
    e.who  = who_v;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    winner_in = 1'b0;
    loser_in  = 1'b0;
    restart   = 1'b0;

    step("reset0", 0, 0, 0, 0, 2'b00);
    step("reset1", 0, 0, 0, 0, 2'b00);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step("idle", 0, 0, 0, 0, 2'b00);

    // Held winner level counts once; init pulses for one cycle.
    winner_in = 1'b1;
    step("win_edge", 1, 0, 1, 0, 2'b00);
    step("win_hold1", 1, 0, 0, 0, 2'b00);
    step("win_hold2", 1, 0, 0, 0, 2'b00);
    winner_in = 1'b0;
    step("win_low", 1, 0, 0, 0, 2'b00);

    winner_in = 1'b1;
    loser_in  = 1'b1;
    step("joint_edge", 2, 1, 1, 0, 2'b00);
    step("joint_hold", 2, 1, 0, 0, 2'b00);
    winner_in = 1'b0;
    loser_in  = 1'b0;
    step("joint_low", 2, 1, 0, 0, 2'b00);

    restart = 1'b1;
    step("restart_a", 0, 0, 1, 0, 2'b00);
    restart = 1'b0;
    step("restart_a_play", 0, 0, 0, 0, 2'b00);

    for (int k = 1; k <= 14; k++) begin
      loser_in = 1'b1;
      step("lose_pulse", 0, k, 1, 0, 2'b00);
      loser_in = 1'b0;
      step("lose_gap", 0, k, 0, 0, 2'b00);
    end
    loser_in = 1'b1;
    step("lose_final", 0, 15, 0, 1, 2'b10);
    loser_in = 1'b0;
    step("over_hold", 0, 15, 0, 1, 2'b10);
    winner_in = 1'b1;
    step("over_ignore_win", 0, 15, 0, 1, 2'b10);
    winner_in = 1'b0;
    step("over_ignore_low", 0, 15, 0, 1, 2'b10);

    restart = 1'b1;
    step("restart_b", 0, 0, 1, 0, 2'b00);
    restart = 1'b0;
    step("restart_b_play", 0, 0, 0, 0, 2'b00);
    for (int k = 1; k <= 14; k++) begin
      winner_in = 1'b1;
      loser_in  = 1'b1;
      step("draw_pulse", k, k, 1, 0, 2'b00);
      winner_in = 1'b0;
      loser_in  = 1'b0;
      step("draw_gap", k, k, 0, 0, 2'b00);
    end
    winner_in = 1'b1;
    loser_in  = 1'b1;
    step("draw_final", 15, 15, 0, 1, 2'b11);
    winner_in = 1'b0;
    loser_in  = 1'b0;
    step("draw_hold", 15, 15, 0, 1, 2'b11);

    // Restart beats a same-cycle winner edge; the held level is not counted later.
    restart   = 1'b1;
    winner_in = 1'b1;
    step("restart_prio", 0, 0, 1, 0, 2'b00);
    restart = 1'b0;
    step("restart_prio_hold", 0, 0, 0, 0, 2'b00);
    winner_in = 1'b0;
    step("restart_prio_low", 0, 0, 0, 0, 2'b00);

    winner_in = 1'b1;
    step("pre_reset_edge", 1, 0, 1, 0, 2'b00);
    winner_in = 1'b0;
    reset     = 1'b1;
    step("reset_in_reload", 0, 0, 0, 0, 2'b00);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step("post_reset_idle", 0, 0, 0, 0, 2'b00);

    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
